// File: rtl/ieeedrv_pkg.sv
// Shared definitions for the drive memory arbiter: arbiter state encoding
// and the width of a client grant index.
package ieeedrv_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_e;

    // Grant index width; supports up to four drive clients.
    localparam int GW = 2;

endpackage

// File: rtl/ieeedrv_rr_pick.sv
// Combinational round-robin picker: the first requester found searching
// upward from (last+1) mod NDR wins; last itself has the lowest priority.
module ieeedrv_rr_pick
    import ieeedrv_pkg::*;
#(
    parameter int NDR = 4
) (
    input  logic [NDR-1:0] req,
    input  logic [GW-1:0]  last,
    output logic           valid,
    output logic [GW-1:0]  grant
);

    int idx;

    always_comb begin
        valid = 1'b0;
        grant = last;
        idx   = 0;
        // Walk from the farthest candidate to the nearest so the nearest wins.
        for (int i = NDR; i >= 1; i--) begin
            idx = (int'(last) + i) % NDR;
            if (req[idx]) begin
                valid = 1'b1;
                grant = GW'(idx);
            end
        end
    end

endmodule

// File: rtl/ieeedrv_mem_arb.sv
// Request/acknowledge arbiter sharing one single-port memory among NDR drive
// clients; one operation in flight, uniform latency for reads and writes.
module ieeedrv_mem_arb
    import ieeedrv_pkg::*;
#(
    parameter int NDR       = 4,
    parameter int ADDRWIDTH = 14,
    parameter int DATAWIDTH = 8,
    parameter int RD_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NDR-1:0]       req,
    input  logic [NDR-1:0]       we,
    input  logic [ADDRWIDTH-1:0] addr  [NDR],
    input  logic [DATAWIDTH-1:0] wdata [NDR],
    output logic [NDR-1:0]       ack,
    output logic [DATAWIDTH-1:0] rdata [NDR],
    output logic [ADDRWIDTH-1:0] mem_addr,
    output logic [DATAWIDTH-1:0] mem_data,
    output logic                 mem_wren,
    input  logic [DATAWIDTH-1:0] mem_q,
    output logic                 busy
);

    localparam int CW = $clog2(RD_LAT + 1);

    arb_state_e           state_q;
    logic [GW-1:0]        last_q;
    logic [GW-1:0]        g_q;
    logic [CW-1:0]        cnt_q;
    logic                 op_we_q;
    logic [NDR-1:0]       ack_q;
    logic [ADDRWIDTH-1:0] mem_addr_q;
    logic [DATAWIDTH-1:0] mem_data_q;
    logic                 mem_wren_q;
    logic                 busy_q;

    logic                 pick_valid;
    logic [GW-1:0]        pick_idx;

    ieeedrv_rr_pick #(
        .NDR (NDR)
    ) u_pick (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .grant (pick_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB_IDLE;
            last_q     <= GW'(NDR - 1);
            g_q        <= '0;
            cnt_q      <= '0;
            op_we_q    <= 1'b0;
            ack_q      <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_wren_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ack_q <= '0;
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        g_q        <= pick_idx;
                        mem_addr_q <= addr[pick_idx];
                        mem_data_q <= wdata[pick_idx];
                        mem_wren_q <= we[pick_idx];
                        op_we_q    <= we[pick_idx];
                        busy_q     <= 1'b1;
                        state_q    <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    mem_wren_q <= 1'b0;
                    cnt_q      <= CW'(RD_LAT - 1);
                    state_q    <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    // Ack is registered here so it is high for the DONE cycle.
                    if (cnt_q == '0) begin
                        ack_q[g_q] <= 1'b1;
                        state_q    <= ARB_DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ARB_DONE: begin
                    last_q  <= g_q;
                    busy_q  <= 1'b0;
                    state_q <= ARB_IDLE;
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    // Per-client read data register, loaded from the memory only on reads.
    for (genvar gi = 0; gi < NDR; gi++) begin : g_rdata
        logic [DATAWIDTH-1:0] rdata_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rdata_q <= '0;
            end else if (state_q == ARB_DONE && !op_we_q && g_q == GW'(gi)) begin
                rdata_q <= mem_q;
            end
        end

        assign rdata[gi] = rdata_q;
    end

    assign ack      = ack_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_wren = mem_wren_q;
    assign busy     = busy_q;

endmodule

// File: doc/ieeedrv_mem_arb.md
# ieeedrv_mem_arb

Shared-memory request/acknowledge arbiter serving up to NDR drive clients on one single-port memory (buffer RAM or ROM port A). Each drive issues a held request with address, write-enable and data. The arbiter grants clients in round-robin order, drives the memory port, waits the fixed memory read latency, and returns read data with a one-cycle acknowledge. It is the request-driven responder counterpart to the fixed-slot drive ROM multiplexer. It sits between the per-drive CPU buses and `ieeedrv_mem` / `ieeedrv_rom`.

## Interface
Parameters:
- `NDR`, 4: number of drive clients, 1..4.
- `ADDRWIDTH`, 14: memory address width.
- `DATAWIDTH`, 8: memory data width.
- `RD_LAT`, 1: memory read latency in clocks, 1..3.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  NDR  per-client request; held high until `ack`.
- `we`  in  NDR  per-client write enable; sampled with `req`.
- `addr`  in  [ADDRWIDTH-1:0] x NDR (unpacked)  per-client address.
- `wdata`  in  [DATAWIDTH-1:0] x NDR (unpacked)  per-client write data.
- `ack`  out  NDR  one-cycle completion pulse per client.
- `rdata`  out  [DATAWIDTH-1:0] x NDR (unpacked)  per-client read data; holds its value until the next read by that client.
- `mem_addr`  out  ADDRWIDTH  memory address.
- `mem_data`  out  DATAWIDTH  memory write data.
- `mem_wren`  out  1  memory write strobe.
- `mem_q`  in  DATAWIDTH  memory read data.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any `req` is high, pick grant index `g` by round-robin. Search starts at `(last+1) mod NDR`.
  - Latch `addr[g]`, `wdata[g]`, `we[g]` into `mem_addr`/`mem_data`/`mem_wren`.
  - Go to ISSUE.
- ISSUE: the memory samples the port. Clear `mem_wren` on exit. Load the latency counter with `RD_LAT-1`. Go to WAIT.
- WAIT: decrement the counter. When it reaches 0, go to DONE.
- DONE:
  - Capture `mem_q` into `rdata[g]`, but only if the operation was a read.
  - Pulse `ack[g]`. Set `last <= g`. Go to IDLE.
- Writes use the same timing as reads, so latency is uniform. `rdata[g]` is untouched on writes.
- Only one operation is outstanding at a time. `addr`/`we`/`wdata` are sampled only in IDLE, so later changes do not affect the operation in flight.
- Client drops `req` after grant: the operation still completes and `ack` still pulses.
- Client keeps `req` high in the cycle after `ack`: this is treated as a new request and arbitrated normally. Clients must drop `req` on seeing `ack`.
- Simultaneous requests: round-robin gives exactly one grant. Any set of continuously-asserted requesters is served within NDR operations.
- Reset values:
  - state IDLE.
  - `last = NDR-1`, so client 0 has first priority.
  - `ack = 0`, `rdata = 0`, `mem_addr = 0`, `mem_data = 0`, `mem_wren = 0`, `busy = 0`.
- `reset_n` asserted mid-operation: everything returns to the reset values immediately. No `ack` is issued and any partially issued write is abandoned. The memory may already have been written if ISSUE was reached.

## Timing
- Cycle 0: `req[g]` high in IDLE.
- Cycle 1: ISSUE. `mem_addr` valid; `mem_wren` high for exactly this cycle on a write.
- Cycles 2..1+RD_LAT: WAIT.
- Cycle 2+RD_LAT: DONE. `ack[g]` is high; `rdata[g]` becomes valid in the cycle after `ack`.
  - Registered capture at the DONE edge: `rdata[g]` valid from cycle 3+RD_LAT. Clients sample it on the cycle after `ack`.
- `req`-to-`ack` latency is 2+RD_LAT cycles, i.e. 3 with the default `RD_LAT=1`.
- Throughput: one operation per 3+RD_LAT cycles, with IDLE revisited between operations.
- `mem_addr` holds its value after DONE until the next grant.

## Structure
- Shared package `ieeedrv_pkg`: the state enum (`ARB_IDLE`, `ARB_ISSUE`, `ARB_WAIT`, `ARB_DONE`). `ieeedrv_mem_arb` reuses it.
- Sub-module `ieeedrv_rr_pick`: purely combinational round-robin picker.
  - Inputs: `req[NDR]`, `last`.
  - Outputs: `valid`, grant index.
- Counter width is `$clog2(RD_LAT+1)`. The grant index is 2 bits.

## Test plan
- Single read: client 1 requests addr 0x0123 with RAM[0x0123]=0xA5 and `RD_LAT=1` → `mem_addr`=0x0123 in cycle 1, `ack[1]` in cycle 3, `rdata[1]`=0xA5 from cycle 4. Other `ack`/`rdata` unchanged.
- Single write: client 2 writes 0x5A to 0x3FFF → `mem_wren` high in cycle 1 only, `ack[2]` in cycle 3, `rdata[2]` unchanged. A follow-up read of 0x3FFF returns 0x5A.
- All four clients request in the same cycle after reset, each holding `req` until its `ack` → acks in order 0,1,2,3 at cycles 3,7,11,15. Each `rdata` matches its own address.
- Fairness: clients 0 and 3 re-request immediately after each `ack` for 8 operations → grants strictly alternate 0,3,0,3…
- Client 0 drops `req` in cycle 1 after grant → `ack[0]` still pulses in cycle 3. `reset_n` low during WAIT → `ack`=0, `busy`=0 and all outputs at reset values, with no `ack` after release.
- `RD_LAT=3`: a read → `ack` at cycle 5 and `rdata` equal to `mem_q` as sampled 3 cycles after ISSUE.
